// File: rtl/wts_channel_sequencer.sv
// wts_channel_sequencer
//   Time-division sequencer for the 6-channel wave table datapath. Each
//   sample period runs channel slots 0..5 (SLOT_CYCLES clocks each) and then
//   an idle window of at least IDLE_CYCLES clocks. CPU register writes are
//   granted only in the idle window, so channel registers stay stable while
//   a channel is being processed.
//
//   Parameters
//     SLOT_CYCLES  clocks per channel slot (>= 3)
//     IDLE_CYCLES  idle clocks after channel 5 before the next period (>= 1)
//
//   Ports
//     clk         system clock
//     nreset      asynchronous active-low reset
//     enable      start a new period when the idle window has elapsed
//     ch_mask     (WTS_CH_MASK_EN only) per-channel mute: slot keeps its
//                 timing but active=7 and ch_start/ch_last are suppressed
//     active      channel index 0..5 during slots, 3'd7 when idle
//     ch_start    first cycle of each channel slot
//     ch_last     last cycle of each channel slot
//     sample_end  last cycle of the channel 5 slot
//     busy        high in any channel slot
//     wr_req      CPU register write request (level, held until wr_ack)
//     wr_ack      write grant; the write commits in the wr_ack cycle
//
//   Build option: define WTS_CH_MASK_EN to add the ch_mask input.

module wts_channel_sequencer #(
   parameter int unsigned SLOT_CYCLES = 4,
   parameter int unsigned IDLE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       enable,
`ifdef WTS_CH_MASK_EN
   input  logic [5:0] ch_mask,
`endif
   output logic [2:0] active,
   output logic       ch_start,
   output logic       ch_last,
   output logic       sample_end,
   output logic       busy,
   input  logic       wr_req,
   output logic       wr_ack
);

   localparam int unsigned SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [2:0]    CH_FINAL  = 3'd5;
   localparam logic [2:0]    CH_NONE   = 3'd7;

   typedef enum logic {
      ST_IDLE,
      ST_SLOT
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
   logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
   logic [2:0]      ch_q, ch_d;
   logic            wr_ack_q;

   logic            in_slot;
   logic            slot_first;
   logic            slot_last;
   logic            ch_on;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= ST_IDLE;
         idle_cnt_q <= '0;
         slot_cnt_q <= '0;
         ch_q       <= '0;
         wr_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         slot_cnt_q <= slot_cnt_d;
         ch_q       <= ch_d;
         wr_ack_q   <= wr_ack;
      end
   end

   // Next state. enable only matters once the idle window has elapsed; a
   // started period always runs through channel 5.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      slot_cnt_d = slot_cnt_q;
      ch_d       = ch_q;
      case (state_q)
         ST_IDLE: begin
            if (idle_cnt_q != IDLE_LAST) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end else if (enable) begin
               state_d    = ST_SLOT;
               ch_d       = '0;
               slot_cnt_d = '0;
            end
         end
         ST_SLOT: begin
            if (slot_cnt_q == SLOT_LAST) begin
               slot_cnt_d = '0;
               if (ch_q == CH_FINAL) begin
                  state_d    = ST_IDLE;
                  idle_cnt_d = '0;
               end else begin
                  ch_d = ch_q + 3'd1;
               end
            end else begin
               slot_cnt_d = slot_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs, decoded from registered state only (plus wr_req for wr_ack).
   always_comb begin
      in_slot    = (state_q == ST_SLOT);
      slot_first = in_slot && (slot_cnt_q == '0);
      slot_last  = in_slot && (slot_cnt_q == SLOT_LAST);
`ifdef WTS_CH_MASK_EN
      ch_on      = ~ch_mask[ch_q];
`else
      ch_on      = 1'b1;
`endif
      active     = (in_slot && ch_on) ? ch_q : CH_NONE;
      ch_start   = slot_first && ch_on;
      ch_last    = slot_last && ch_on;
      // Masking never hides the period boundary.
      sample_end = slot_last && (ch_q == CH_FINAL);
      busy       = in_slot;
      // Back-to-back grants are blocked so the requester has a cycle to
      // update or drop wr_req after each ack.
      wr_ack     = (state_q == ST_IDLE) && wr_req && !wr_ack_q;
   end

endmodule

// File: tb/tb_wts_channel_sequencer.sv
// Testbench for wts_channel_sequencer: default instance (4/8) and a minimum
// timing instance (3/1) share stimulus; a scoreboard holds per-cycle expected
// outputs from a period-position model of the sequencer.

module tb_wts_channel_sequencer;

   localparam int NI = 2;

   typedef struct packed {
      logic [2:0] active;
      logic       ch_start;
      logic       ch_last;
      logic       sample_end;
      logic       busy;
      logic       wr_ack;
   } exp_t;

   logic clk = 1'b0;
   logic nreset;
   logic enable;
   logic wr_req;
`ifdef WTS_CH_MASK_EN
   logic [5:0] ch_mask = 6'b000100;
`endif

   logic [2:0] active_o     [NI];
   logic       ch_start_o   [NI];
   logic       ch_last_o    [NI];
   logic       sample_end_o [NI];
   logic       busy_o       [NI];
   logic       wr_ack_o     [NI];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int          cyc     = 0;
   int          acks0   = 0;
   logic        per_chk = 1'b0;
   int          last_se [NI];
   exp_t        sb[$];

   int          pos  [NI];
   logic        pack [NI];

   always #5 clk = ~clk;

   wts_channel_sequencer #(
      .SLOT_CYCLES(4),
      .IDLE_CYCLES(8)
   ) u_dut0 (
      .clk        (clk),
      .nreset     (nreset),
      .enable     (enable),
`ifdef WTS_CH_MASK_EN
      .ch_mask    (ch_mask),
`endif
      .active     (active_o[0]),
      .ch_start   (ch_start_o[0]),
      .ch_last    (ch_last_o[0]),
      .sample_end (sample_end_o[0]),
      .busy       (busy_o[0]),
      .wr_req     (wr_req),
      .wr_ack     (wr_ack_o[0])
   );

   wts_channel_sequencer #(
      .SLOT_CYCLES(3),
      .IDLE_CYCLES(1)
   ) u_dut1 (
      .clk        (clk),
      .nreset     (nreset),
      .enable     (enable),
`ifdef WTS_CH_MASK_EN
      .ch_mask    (ch_mask),
`endif
      .active     (active_o[1]),
      .ch_start   (ch_start_o[1]),
      .ch_last    (ch_last_o[1]),
      .sample_end (sample_end_o[1]),
      .busy       (busy_o[1]),
      .wr_req     (wr_req),
      .wr_ack     (wr_ack_o[1])
   );

   function automatic int slot_of(input int i);
      return (i == 0) ? 4 : 3;
   endfunction

   function automatic int idle_of(input int i);
      return (i == 0) ? 8 : 1;
   endfunction

   function automatic int per_of(input int i);
      return 6 * slot_of(i) + idle_of(i);
   endfunction

   // Expected outputs from the position within the period.
   function automatic exp_t model_out(input int i, input logic req);
      exp_t e;
      int   s   = slot_of(i);
      int   id  = idle_of(i);
      int   off = pos[i] - id;
      logic idl = (pos[i] < id);
      e.active     = idl ? 3'd7 : 3'(off / s);
      e.ch_start   = !idl && (off % s == 0);
      e.ch_last    = !idl && (off % s == s - 1);
      e.sample_end = (pos[i] == per_of(i) - 1);
      e.busy       = !idl;
      e.wr_ack     = idl && req && !pack[i];
`ifdef WTS_CH_MASK_EN
      if (!idl && ch_mask[off / s]) begin
         e.active   = 3'd7;
         e.ch_start = 1'b0;
         e.ch_last  = 1'b0;
      end
`endif
      return e;
   endfunction

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NI; i++) begin
            pos[i]  <= 0;
            pack[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            pack[i] <= model_out(i, wr_req).wr_ack;
            if (pos[i] == idle_of(i) - 1)
               pos[i] <= enable ? pos[i] + 1 : pos[i];
            else if (pos[i] == per_of(i) - 1)
               pos[i] <= 0;
            else
               pos[i] <= pos[i] + 1;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic push_cycle();
      exp_t e;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         e = model_out(i, wr_req);
         sb.push_back(e);
         if (i == 0 && e.wr_ack) acks0++;
      end
   endtask

   task automatic drive(input logic en, input logic req);
      @(posedge clk);
      #1;
      enable = en;
      wr_req = req;
      push_cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("%s_active%0d", tag, i), 32'(active_o[i]), 32'd7);
         check_val($sformatf("%s_start%0d", tag, i), 32'(ch_start_o[i]), 32'd0);
         check_val($sformatf("%s_last%0d", tag, i), 32'(ch_last_o[i]), 32'd0);
         check_val($sformatf("%s_send%0d", tag, i), 32'(sample_end_o[i]), 32'd0);
         check_val($sformatf("%s_busy%0d", tag, i), 32'(busy_o[i]), 32'd0);
         check_val($sformatf("%s_ack%0d", tag, i), 32'(wr_ack_o[i]), 32'd0);
      end
   endtask

   task automatic wait_pos0(input int target, input string tag);
      int n = 0;
      while (pos[0] != target && n < 40) begin
         drive(1'b1, 1'b0);
         n++;
      end
      check_val(tag, 32'(pos[0]), 32'(target));
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NI; i++) begin
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val($sformatf("active%0d", i), 32'(active_o[i]), 32'(e.active));
            check_val($sformatf("ch_start%0d", i), 32'(ch_start_o[i]), 32'(e.ch_start));
            check_val($sformatf("ch_last%0d", i), 32'(ch_last_o[i]), 32'(e.ch_last));
            check_val($sformatf("sample_end%0d", i), 32'(sample_end_o[i]), 32'(e.sample_end));
            check_val($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(e.busy));
            check_val($sformatf("wr_ack%0d", i), 32'(wr_ack_o[i]), 32'(e.wr_ack));
         end
         if (per_chk && sample_end_o[i]) begin
            if (last_se[i] >= 0)
               check_val($sformatf("se_period%0d", i), 32'(cyc - last_se[i]), 32'(per_of(i)));
            last_se[i] = cyc;
         end
      end
   end

   initial begin
      int n;
      nreset = 1'b0;
      enable = 1'b0;
      wr_req = 1'b0;
      for (int i = 0; i < NI; i++) last_se[i] = -1;

      // reset state
      #12;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      nreset = 1'b1;
      enable = 1'b1;
      push_cycle();

      // continuous periods with enable held
      per_chk = 1'b1;
      repeat (70) drive(1'b1, 1'b0);
      per_chk = 1'b0;

      // write request raised during channel 2, three writes
      wait_pos0(16, "wait_ch2");
      acks0 = 0;
      n = 0;
      while (acks0 < 3 && n < 60) begin
         drive(1'b1, 1'b1);
         n++;
      end
      check_val("three_acks", 32'(acks0), 32'd3);
      drive(1'b1, 1'b0);

      // enable dropped during channel 3, held write requests while parked
      wait_pos0(20, "wait_ch3");
      repeat (50) drive(1'b0, 1'b1);
      repeat (20) drive(1'b1, 1'b0);

      // asynchronous reset in the middle of the channel 4 slot
      wait_pos0(25, "wait_ch4");
      @(posedge clk);
      #3;
      nreset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      sb.delete();
      @(posedge clk);
      #1;
      nreset = 1'b1;
      enable = 1'b1;
      wr_req = 1'b0;
      push_cycle();
      repeat (40) drive(1'b1, 1'b0);

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
